spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_arbiter_if.sv | 50 +++++
 rtl/spi_rr_arbiter.sv | 29 ++
 rtl/spi_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM state encoding
// for the SPI master arbiter.
package spi_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester and SPI-master side signals
// of the arbiter; slave = arbiter, master = environment.
interface spi_arbiter_if
  import spi_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      master_start;
  logic [DATA_W-1:0]         master_data_in;
  logic                      master_done;
  logic [DATA_W-1:0]         master_data_out;
  logic                      busy;

  modport slave (
    input  req_valid,
    input  req_data,
    input  master_done,
    input  master_data_out,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err,
    output master_start,
    output master_data_in,
    output busy
  );

  modport master (
    output req_valid,
    output req_data,
    output master_done,
    output master_data_out,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err,
    input  master_start,
    input  master_data_in,
    input  busy
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick, searching
// upward from last_grant+1 with wrap-around.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LG_W    = 2
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [LG_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
  input logic          clk,
  input logic          reset,
  spi_arbiter_if.slave bus
);

  localparam int LG_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LG_W-1:0] LAST_RST =
    LG_W'(NUM_REQ - 1);

  state_e            state_q, state_d;
  logic [LG_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;

  logic [NUM_REQ-1:0] grant;
  logic [LG_W-1:0]    win_idx;
  logic [DATA_W-1:0]  win_data;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LG_W    (LG_W)
  ) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = LG_W'(i);
    end
  end

  assign win_data =
    bus.req_data[win_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      tx_q    <= '0;
      rx_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_ISSUE;
          last_d  = win_idx;
          tx_d    = win_data;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.master_done) begin
          state_d = ST_RESP;
          rx_d    = bus.master_data_out;
`ifdef SPI_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (timeout) begin
          // give up: report an error with a zero byte
          state_d = ST_RESP;
          rx_d    = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.rsp_valid    = '0;
    bus.master_start = 1'b0;
    bus.busy         = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (!reset) bus.req_ready = grant;
      end
      ST_ISSUE: bus.master_start = 1'b1;
      ST_WAIT:  bus.busy = 1'b1;
      ST_RESP:  bus.rsp_valid[last_q] = 1'b1;
      default:  bus.busy = 1'b1;
    endcase
  end

  assign bus.rsp_data       = rx_q;
  assign bus.master_data_in = tx_q;

`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.rsp_err = err_q && (state_q == ST_RESP);
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: random and directed transactions checked
// against a round-robin transaction-level reference model.
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  spi_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  spi_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int last_m = N - 1;
  logic [W-1:0] slot [N];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v,
                                 input int last);
    int i;
    i = last;
    repeat (N) begin
      i = (i == N - 1) ? 0 : i + 1;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic txn(input logic [N-1:0] vld,
                     input int dly,
                     input bit glitch,
                     input bit scramble,
                     input logic [W-1:0] wdata,
                     input logic [W-1:0] rx,
                     output int who);
    int w;
    w = rr_pick(vld, last_m);
    for (int i = 0; i < N; i++) slot[i] = W'($urandom);
    if (w >= 0) slot[w] = wdata;
    for (int i = 0; i < N; i++)
      bus.req_data[i*W +: W] = slot[i];
    if (glitch) begin
      bus.req_valid   = '0;
      bus.master_done = 1'b1;
      smp();
      chk("idle_done_rsp", 32'(bus.rsp_valid), 0);
      chk("idle_done_busy", 32'(bus.busy), 0);
      tick();
      bus.master_done = 1'b0;
    end
    bus.req_valid = vld;
    smp();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("grant", 32'(bus.req_ready), 32'(1) << w);
    tick();
    if (scramble) bus.req_valid = N'($urandom);
    if (glitch) bus.master_done = 1'b1;
    smp();
    chk("issue_start", 32'(bus.master_start), 1);
    chk("issue_tx", 32'(bus.master_data_in), 32'(slot[w]));
    chk("issue_ready", 32'(bus.req_ready), 0);
    chk("issue_rsp", 32'(bus.rsp_valid), 0);
    tick();
    bus.master_done = 1'b0;
    repeat (dly) begin
      smp();
      chk("wait_rsp", 32'(bus.rsp_valid), 0);
      chk("wait_start", 32'(bus.master_start), 0);
      tick();
    end
    bus.master_data_out = rx;
    bus.master_done     = 1'b1;
    smp();
    chk("wait_tx", 32'(bus.master_data_in), 32'(slot[w]));
    chk("wait_busy", 32'(bus.busy), 1);
    tick();
    bus.master_done     = 1'b0;
    bus.master_data_out = W'($urandom);
    smp();
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << w);
    chk("rsp_data", 32'(bus.rsp_data), 32'(rx));
    chk("rsp_err", 32'(bus.rsp_err), 0);
    chk("rsp_ready", 32'(bus.req_ready), 0);
    chk("rsp_tx", 32'(bus.master_data_in), 32'(slot[w]));
    tick();
    bus.req_valid = '0;
    last_m = w;
    who    = w;
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset         = 1'b1;
    bus.req_valid = '1;
    #1;
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_start"}, 32'(bus.master_start), 0);
    chk({tag, "_rsp"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_tx"}, 32'(bus.master_data_in), 0);
    chk({tag, "_rx"}, 32'(bus.rsp_data), 0);
    chk({tag, "_err"}, 32'(bus.rsp_err), 0);
    tick();
    tick();
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = '0;
    last_m        = N - 1;
    tick();
  endtask

  task automatic accept(input logic [N-1:0] vld,
                        input int extra);
    bus.req_valid = vld;
    tick();
    bus.req_valid = '0;
    repeat (extra) tick();
  endtask

  initial begin
    int who;
    int n;
    logic [N-1:0] v;
    bus.req_valid       = '1;
    bus.req_data        = '0;
    bus.master_done     = 1'b0;
    bus.master_data_out = '0;
    #3;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_start", 32'(bus.master_start), 0);
    chk("rst_rsp", 32'(bus.rsp_valid), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_tx", 32'(bus.master_data_in), 0);
    chk("rst_rx", 32'(bus.rsp_data), 0);
    chk("rst_err", 32'(bus.rsp_err), 0);
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = '0;
    tick();

    txn(4'b0001, 2, 1'b0, 1'b0, 8'hA5, 8'hF0, who);

    async_reset("rst2");
    repeat (5)
      txn(4'b1111, 1, 1'b0, 1'b0,
          W'($urandom), W'($urandom), who);

    txn(4'b0100, 0, 1'b0, 1'b0, 8'h11, 8'h22, who);
    txn(4'b0011, 0, 1'b0, 1'b0, 8'h33, 8'h44, who);
    txn(4'b0011, 1, 1'b0, 1'b0, 8'h55, 8'h66, who);

    txn(4'b0110, 3, 1'b1, 1'b0, 8'h77, 8'h88, who);

    for (int t = 0; t < 40; t++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      txn(v, $urandom_range(0, 5),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          W'($urandom), W'($urandom), who);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    bus.master_data_out = 8'h5A;
    who = rr_pick(4'b1000, last_m);
    accept(4'b1000, 0);
    n = 0;
    while (n < 200) begin
      smp();
      if (bus.rsp_valid != '0) break;
      n++;
      tick();
    end
    chk("to_cycles", n, 1 + TO);
    chk("to_rsp", 32'(bus.rsp_valid), 32'(1) << who);
    chk("to_err", 32'(bus.rsp_err), 1);
    chk("to_data", 32'(bus.rsp_data), 0);
    tick();
    last_m = who;
`else
    accept(4'b1000, 0);
    n = 0;
    repeat (150) begin
      smp();
      if (bus.busy && bus.rsp_valid == '0) n++;
      tick();
    end
    chk("hang_busy", n, 150);
    async_reset("rst_hang");
`endif

    accept(4'b0010, 0);
    async_reset("rst_issue");
    txn(4'b1111, 1, 1'b0, 1'b0, 8'h9C, 8'h3E, who);

    accept(4'b0100, 2);
    async_reset("rst_wait");
    txn(4'b1111, 0, 1'b0, 1'b0, 8'hC3, 8'h7B, who);
    txn(4'b1111, 0, 1'b0, 1'b0, 8'h12, 8'h34, who);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
